// File: rtl/sysctrl_arb_pkg.sv
// Shared types and constants for the system-control Wishbone arbiter.
package sysctrl_arb_pkg;

  localparam int NM_MAX = 4;
  localparam int ADR_W  = 32;
  localparam int DAT_W  = 32;
  localparam int SEL_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // One master's request as it is forwarded to the slave port.
  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/sysctrl_rr_pick.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// requester found when searching upward from last+1, wrapping at NM.
module sysctrl_rr_pick
  import sysctrl_arb_pkg::*;
#(
  parameter int NM    = 2,
  parameter int IDX_W = $clog2(NM)
) (
  input  logic [NM-1:0]    req,
  input  logic [IDX_W-1:0] last,
  output logic [NM-1:0]    gnt
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan NM candidates starting just after the previous winner.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NM; i++) begin
      idx = IDX_W'((int'(last) + i) % NM);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysctrl_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the sysctrl register slave between NM
// masters. One master owns the slave for a whole bus tenure (while its cyc is
// high); ack is routed back only to that master.
// Optional stall timeout: define SYSCTRL_ARB_TIMEOUT_EN to abort a strobe that
// has waited TIMEOUT cycles without ack, signalled as a one-cycle m_err_o.
module sysctrl_wb_arbiter
  import sysctrl_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic [NM-1:0]       m_cyc_i,
  input  logic [NM-1:0]       m_stb_i,
  input  logic [NM-1:0]       m_we_i,
  input  logic [4*NM-1:0]     m_sel_i,
  input  logic [32*NM-1:0]    m_adr_i,
  input  logic [32*NM-1:0]    m_dat_i,
  output logic [31:0]         m_dat_o,
  output logic [NM-1:0]       m_ack_o,
  output logic [NM-1:0]       m_err_o,
  output logic [NM-1:0]       gnt_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [3:0]          s_sel_o,
  output logic [31:0]         s_adr_o,
  output logic [31:0]         s_dat_o,
  input  logic [31:0]         s_dat_i,
  input  logic                s_ack_i
);

  localparam int IDX_W = $clog2(NM);

  arb_state_e       state_q, state_d;
  logic [NM-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [NM-1:0]    req;
  logic [NM-1:0]    pick_gnt;
  logic [IDX_W-1:0] g_idx;
  wb_req_t          g_req;
  logic             busy;
  logic             g_strobe;
  logic             tmo_fire;

  assign req  = m_cyc_i & m_stb_i;
  assign busy = (state_q == ST_BUSY);

  sysctrl_rr_pick #(
    .NM    (NM),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  // Mux the granted master's request; stays all-zero while no grant is held.
  always_comb begin
    g_req = '0;
    g_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i]) begin
        g_idx     = IDX_W'(i);
        g_req.cyc = m_cyc_i[i];
        g_req.stb = m_stb_i[i];
        g_req.we  = m_we_i[i];
        g_req.sel = m_sel_i[i*SEL_W +: SEL_W];
        g_req.adr = m_adr_i[i*ADR_W +: ADR_W];
        g_req.dat = m_dat_i[i*DAT_W +: DAT_W];
      end
    end
  end

  assign g_strobe = busy & g_req.cyc & g_req.stb;

  // Next-state logic: grant on any request in IDLE, release when the owner drops cyc.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_req.cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = g_idx;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Arbitration state register; last starts at NM-1 so master 0 wins first.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!wb_rstn_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NM - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef SYSCTRL_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Fire when a strobe has stalled TIMEOUT cycles; a same-cycle ack takes priority.
  assign tmo_fire = g_strobe & ~s_ack_i & (timer_q == TMR_W'(TIMEOUT));

  // Count stalled strobe cycles; clear on ack, strobe low, release or abort.
  always_comb begin
    timer_d = '0;
    if (g_strobe && !s_ack_i && !tmo_fire) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Stall timer register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Slave side: combinational copy of the owner; strobe is masked on a timeout abort.
  assign s_cyc_o = busy & g_req.cyc;
  assign s_stb_o = g_strobe & ~tmo_fire;
  assign s_we_o  = g_req.we;
  assign s_sel_o = g_req.sel;
  assign s_adr_o = g_req.adr;
  assign s_dat_o = g_req.dat;

  // Master side: data is broadcast, ack/err reach only the owner while it still strobes.
  assign m_dat_o = s_dat_i;
  assign m_ack_o = gnt_q & {NM{g_strobe & s_ack_i}};
  assign m_err_o = gnt_q & {NM{tmo_fire}};
  assign gnt_o   = gnt_q;

endmodule
